// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Holds the FSM encoding and the double-dabble correction constants.
package bin2bcd_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] ADJ_THRESH = 4'd5;
    localparam logic [3:0] ADJ_INC    = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Per-digit double-dabble correction: add 3 to any digit of 5 or more.
// Purely combinational; one instance per BCD digit.
module bcd_digit_adj
    import bin2bcd_seq_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= ADJ_THRESH) ? d + ADJ_INC : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter, one operand bit per clock.
// Result register is only written on the final shift, so it holds between runs.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 4
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET_N,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd_out
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = DIGITS * 4;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opnd;
    logic [BW-1:0]    scratch;
    logic [BW-1:0]    adj;
    logic [BW-1:0]    shifted;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (scratch[4*i +: 4]),
            .q (adj[4*i +: 4])
        );
    end

    // Correction precedes the shift, so the last shift is never corrected.
    assign shifted = (adj << 1) | {{(BW-1){1'b0}}, opnd[WIDTH-1]};

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            opnd    <= '0;
            scratch <= '0;
            bcd_out <= '0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        opnd    <= bin_in;
                        scratch <= '0;
                        cnt     <= CW'(WIDTH);
                        state   <= ST_SHIFT;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end else begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    scratch <= shifted;
                    opnd    <= opnd << 1;
                    cnt     <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        bcd_out <= shifted;
                        state   <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 10: width of the binary operand.
REQ-002 The block SHALL have parameter DIGITS, default 4: number of BCD output digits; DIGITS*4 SHALL hold 2^WIDTH-1.
REQ-003 The block SHALL have port CLOCK_50  input  1  system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RESET_N  input  1  reset; one clock, synchronous, active-low.
REQ-005 The block SHALL have port start  input  1  request to convert bin_in; sampled each rising edge.
REQ-006 The block SHALL have port bin_in  input  WIDTH  unsigned binary operand; sampled only on an accepted start.
REQ-007 The block SHALL have port busy  output  1  high while a conversion is in progress.
REQ-008 The block SHALL have port done  output  1  single-cycle pulse when bcd_out is updated.
REQ-009 The block SHALL have port bcd_out  output  DIGITS*4  packed BCD result, digit 0 in bits [3:0].

Function
REQ-010 The block SHALL implement an iterative shift-and-add-3 (double dabble) conversion: one operand bit per clock.
REQ-011 The FSM SHALL have states IDLE, SHIFT, DONE.
REQ-012 In IDLE or DONE, start=1 SHALL be accepted: bin_in copied to a shift register, scratch BCD register cleared, bit counter loaded with WIDTH, next state SHIFT.
REQ-013 In IDLE or DONE, start=0 SHALL give next state IDLE.
REQ-014 In SHIFT, each cycle SHALL first add 3 to every scratch digit >= 5, then shift {scratch, operand} left by one, operand MSB entering scratch bit 0.
REQ-015 In SHIFT, the counter SHALL decrement each cycle; the cycle it reaches 0 SHALL give next state DONE and load bcd_out from the final scratch value.
REQ-016 The add-3 correction SHALL never be applied after the last shift.
REQ-017 start asserted while in SHIFT SHALL be ignored: no restart, no queuing, bin_in not sampled.
REQ-018 busy SHALL be 1 exactly in SHIFT; done SHALL be 1 exactly in DONE (one cycle).
REQ-019 Latency: start accepted at edge N SHALL give done=1 in the cycle after edge N+WIDTH, with bcd_out valid from that cycle.
REQ-020 bcd_out SHALL hold its last value until the next conversion completes; it SHALL not change during SHIFT.
REQ-021 A start accepted in DONE SHALL begin a new conversion immediately (back-to-back, WIDTH+1 cycles per result).
REQ-022 Every output digit SHALL be in range 0..9 for any bin_in; no overflow indication is required.

Reset
REQ-023 RESET_N=0 at a rising edge SHALL force state IDLE, busy=0, done=0, bcd_out=0, and clear counter, shift and scratch registers.
REQ-024 Reset during SHIFT SHALL abort the conversion with no done pulse; a start held high during reset SHALL not be accepted until the first edge with RESET_N=1.

Structure
REQ-025 The FSM state encoding and the add-3 threshold (5) and increment (3) constants SHALL live in a shared package used by the BCD blocks.
REQ-026 The per-digit correction SHALL be a sub-module bcd_digit_adj (4-bit in, 4-bit out, combinational), instantiated DIGITS times.
REQ-027 Only the FSM, counter, operand shift register, scratch register and bcd_out register SHALL be sequential.

Verification
REQ-028 bin_in=0, start pulse -> done after 11 cycles, bcd_out=16'h0000.
REQ-029 bin_in=1023 -> bcd_out=16'h1023; bin_in=999 -> 16'h0999; bin_in=640 -> 16'h0640.
REQ-030 start=1 with bin_in=5, then start pulse with bin_in=7 three cycles later -> single done, bcd_out=16'h0005.
REQ-031 start held high continuously, bin_in=42 -> done every 11 cycles, bcd_out=16'h0042, busy low only in DONE.
REQ-032 RESET_N low for one cycle mid-SHIFT -> busy=0, done never pulses, bcd_out=0; next start with bin_in=512 -> 16'h0512.
REQ-033 Exhaustive sweep of all 1024 bin_in values SHALL match a reference decimal model.
